// File: rtl/pcs_autoneg_ctrl.sv
// pcs_autoneg_ctrl -- 1000BASE-X PCS auto-negotiation controller.
//
// Sequences the transmit path through CONFIGURATION, IDLE and DATA. It
// drives the /C/ config word from received base pages, acknowledges,
// idles and the link timer.
//
// Build option: define AN_FAST_TIMER_EN to fix the link-timer terminal
// count at 15 (16-cycle expiry) for simulation and bring-up.
//
// Ports:
//   GTX_CLK            clock, rising edge
//   mr_main_reset      asynchronous active-high reset
//   mr_an_enable       management AN enable (level)
//   mr_restart_an      restart request (one-cycle pulse)
//   sync_status        receive synchronization OK (level)
//   mr_adv_ability     local base page (bit 14 ignored)
//   rx_config_valid    strobe: rx_config_reg holds a decoded /C/ word
//   rx_config_reg      decoded received config word
//   rx_idle            strobe: an /I/ set was decoded
//   xmit               001 CONFIGURATION, 010 IDLE, 100 DATA (registered)
//   tx_config_reg      config word to transmit (registered)
//   mr_an_complete     negotiation complete (registered)
//   mr_lp_adv_ability  latched link-partner base page (registered)
module pcs_autoneg_ctrl #(
  parameter int LINK_TIMER = 1250000,
  parameter int TIMER_W    = 21
) (
  input  logic        GTX_CLK,
  input  logic        mr_main_reset,
  input  logic        mr_an_enable,
  input  logic        mr_restart_an,
  input  logic        sync_status,
  input  logic [15:0] mr_adv_ability,
  input  logic        rx_config_valid,
  input  logic [15:0] rx_config_reg,
  input  logic        rx_idle,
  output logic [2:0]  xmit,
  output logic [15:0] tx_config_reg,
  output logic        mr_an_complete,
  output logic [15:0] mr_lp_adv_ability
);

  localparam logic [2:0] ST_AN_ENABLE       = 3'd0;
  localparam logic [2:0] ST_AN_RESTART      = 3'd1;
  localparam logic [2:0] ST_ABILITY_DETECT  = 3'd2;
  localparam logic [2:0] ST_ACK_DETECT      = 3'd3;
  localparam logic [2:0] ST_COMPLETE_ACK    = 3'd4;
  localparam logic [2:0] ST_IDLE_DETECT     = 3'd5;
  localparam logic [2:0] ST_LINK_OK         = 3'd6;
  localparam logic [2:0] ST_AN_DISABLE_LINK = 3'd7;

  localparam logic [2:0] XMIT_CONFIG = 3'b001;
  localparam logic [2:0] XMIT_IDLE   = 3'b010;
  localparam logic [2:0] XMIT_DATA   = 3'b100;

`ifdef AN_FAST_TIMER_EN
  localparam logic [TIMER_W-1:0] TIMER_TC = TIMER_W'(15);
`else
  localparam logic [TIMER_W-1:0] TIMER_TC = TIMER_W'(LINK_TIMER - 1);
`endif

  // Clears the acknowledge bit so base pages compare independently of it.
  function automatic logic [15:0] mask_ack(input logic [15:0] w);
    return w & 16'hBFFF;
  endfunction

  // Saturating 0..3 match counter increment.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  logic [2:0]         state_r, next_state_s;
  logic               entry_s;
  logic [TIMER_W-1:0] timer_cnt_r;
  logic               timer_done_s;
  logic [1:0]         abil_cnt_r, ack_cnt_r, idle_cnt_r;
  logic [15:0]        last_word_r;
  logic               ability_match_r, ack_match_r, idle_match_r;
  logic [15:0]        match_word_r;
  logic               zero_match_s, ability_nz_s, consistency_s;
  logic [2:0]         xmit_s, xmit_r;
  logic [15:0]        tx_cfg_s, tx_cfg_r, lp_adv_r;
  logic               complete_s, complete_r;

  assign entry_s       = (next_state_s != state_r);
  assign timer_done_s  = (timer_cnt_r == TIMER_TC);
  assign zero_match_s  = ability_match_r && (match_word_r == 16'h0000);
  assign ability_nz_s  = ability_match_r && (match_word_r != 16'h0000);
  assign consistency_s = (match_word_r == lp_adv_r);

  // Link timer: restarts on every state entry, saturates at terminal count.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      timer_cnt_r <= '0;
    end else if (entry_s) begin
      timer_cnt_r <= '0;
    end else if (!timer_done_s) begin
      timer_cnt_r <= timer_cnt_r + TIMER_W'(1);
    end else begin
      timer_cnt_r <= timer_cnt_r;
    end
  end

  // Match detectors. The match flags are registered one cycle behind the
  // counters, so the third strobe at edge N becomes a transition at N+2.
  // A config word takes precedence over a coincident idle strobe.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      abil_cnt_r      <= 2'd0;
      ack_cnt_r       <= 2'd0;
      idle_cnt_r      <= 2'd0;
      last_word_r     <= 16'h0000;
      ability_match_r <= 1'b0;
      ack_match_r     <= 1'b0;
      idle_match_r    <= 1'b0;
      match_word_r    <= 16'h0000;
    end else if (entry_s) begin
      abil_cnt_r      <= 2'd0;
      ack_cnt_r       <= 2'd0;
      idle_cnt_r      <= 2'd0;
      last_word_r     <= 16'h0000;
      ability_match_r <= 1'b0;
      ack_match_r     <= 1'b0;
      idle_match_r    <= 1'b0;
      match_word_r    <= 16'h0000;
    end else begin
      ability_match_r <= (abil_cnt_r == 2'd3);
      ack_match_r     <= (ack_cnt_r == 2'd3);
      idle_match_r    <= (idle_cnt_r == 2'd3);
      match_word_r    <= mask_ack(last_word_r);
      if (rx_config_valid) begin
        idle_cnt_r  <= 2'd0;
        last_word_r <= rx_config_reg;
        if ((abil_cnt_r != 2'd0) &&
            (mask_ack(rx_config_reg) == mask_ack(last_word_r))) begin
          abil_cnt_r <= sat_inc(abil_cnt_r);
        end else begin
          abil_cnt_r <= 2'd1;
        end
        if (!rx_config_reg[14]) begin
          ack_cnt_r <= 2'd0;
        end else if ((ack_cnt_r != 2'd0) && (rx_config_reg == last_word_r)) begin
          ack_cnt_r <= sat_inc(ack_cnt_r);
        end else begin
          ack_cnt_r <= 2'd1;
        end
      end else if (rx_idle) begin
        abil_cnt_r <= 2'd0;
        ack_cnt_r  <= 2'd0;
        idle_cnt_r <= sat_inc(idle_cnt_r);
      end else begin
        abil_cnt_r <= abil_cnt_r;
        ack_cnt_r  <= ack_cnt_r;
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  // Next-state logic: sync loss, then restart, then normal transitions.
  always_comb begin
    next_state_s = state_r;
    if (!sync_status) begin
      next_state_s = ST_AN_ENABLE;
    end else if (mr_restart_an) begin
      next_state_s = ST_AN_ENABLE;
    end else begin
      case (state_r)
        ST_AN_ENABLE: begin
          if (mr_an_enable) next_state_s = ST_AN_RESTART;
          else              next_state_s = ST_AN_DISABLE_LINK;
        end
        ST_AN_RESTART: begin
          if (timer_done_s) next_state_s = ST_ABILITY_DETECT;
          else              next_state_s = state_r;
        end
        ST_ABILITY_DETECT: begin
          if (ability_nz_s) next_state_s = ST_ACK_DETECT;
          else              next_state_s = state_r;
        end
        ST_ACK_DETECT: begin
          if (ack_match_r && consistency_s)                    next_state_s = ST_COMPLETE_ACK;
          else if ((ack_match_r && !consistency_s) || zero_match_s) next_state_s = ST_AN_ENABLE;
          else                                                 next_state_s = state_r;
        end
        ST_COMPLETE_ACK: begin
          if (zero_match_s)
            next_state_s = ST_AN_ENABLE;
          else if (timer_done_s && (ability_nz_s || !ability_match_r))
            next_state_s = ST_IDLE_DETECT;
          else
            next_state_s = state_r;
        end
        ST_IDLE_DETECT: begin
          if (zero_match_s)                       next_state_s = ST_AN_ENABLE;
          else if (timer_done_s && idle_match_r)  next_state_s = ST_LINK_OK;
          else                                    next_state_s = state_r;
        end
        ST_LINK_OK: begin
          if (ability_match_r) next_state_s = ST_AN_ENABLE;
          else                 next_state_s = state_r;
        end
        ST_AN_DISABLE_LINK: begin
          if (mr_an_enable) next_state_s = ST_AN_ENABLE;
          else              next_state_s = state_r;
        end
        default: next_state_s = ST_AN_ENABLE;
      endcase
    end
  end

  // Moore outputs decoded from the next state so they register with it.
  always_comb begin
    xmit_s     = XMIT_CONFIG;
    tx_cfg_s   = 16'h0000;
    complete_s = 1'b0;
    case (next_state_s)
      ST_AN_ENABLE, ST_AN_RESTART: begin
        xmit_s   = XMIT_CONFIG;
        tx_cfg_s = 16'h0000;
      end
      ST_ABILITY_DETECT: tx_cfg_s = mask_ack(mr_adv_ability);
      ST_ACK_DETECT, ST_COMPLETE_ACK: tx_cfg_s = mr_adv_ability | 16'h4000;
      ST_IDLE_DETECT: begin
        xmit_s   = XMIT_IDLE;
        tx_cfg_s = mr_adv_ability | 16'h4000;
      end
      ST_LINK_OK: begin
        xmit_s     = XMIT_DATA;
        tx_cfg_s   = mr_adv_ability | 16'h4000;
        complete_s = 1'b1;
      end
      ST_AN_DISABLE_LINK: xmit_s = XMIT_DATA;
      default: begin
        xmit_s     = XMIT_CONFIG;
        tx_cfg_s   = 16'h0000;
        complete_s = 1'b0;
      end
    endcase
  end

  // State and output registers; partner page latched only on ability accept.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_r    <= ST_AN_ENABLE;
      xmit_r     <= XMIT_CONFIG;
      tx_cfg_r   <= 16'h0000;
      complete_r <= 1'b0;
      lp_adv_r   <= 16'h0000;
    end else begin
      state_r    <= next_state_s;
      xmit_r     <= xmit_s;
      tx_cfg_r   <= tx_cfg_s;
      complete_r <= complete_s;
      if ((state_r == ST_ABILITY_DETECT) && (next_state_s == ST_ACK_DETECT)) begin
        lp_adv_r <= match_word_r;
      end else begin
        lp_adv_r <= lp_adv_r;
      end
    end
  end

  assign xmit              = xmit_r;
  assign tx_config_reg     = tx_cfg_r;
  assign mr_an_complete    = complete_r;
  assign mr_lp_adv_ability = lp_adv_r;

endmodule
